// File: rtl/lapido_pkg.sv
// Lapido shared definitions: opcode classes, NOP word, fetch FSM states.
package lapido_pkg;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_ALU   = 3'b001;
  localparam logic [2:0] OP_CONST = 3'b010;
  localparam logic [2:0] OP_MEM   = 3'b100;
  localparam logic [2:0] OP_CTRL  = 3'b101;

  localparam logic [31:0] NOP_WORD = 32'h0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_HOLD,
    ST_BWAIT
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Lapido instruction fetch: PC, imem handshake, control-transfer stall.
// Squash lets a redirect land without aborting an outstanding bus cycle.
module fetch_unit
  import lapido_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [31:0]           imem_data,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  branch_done,
  output logic [31:0]           instruction,
  output logic                  instr_valid,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] pc_next
);

  localparam logic [ADDR_WIDTH-1:0] ONE = 1;

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] pcn_q;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] tgt_q, tgt_d;
  logic [31:0]           instr_q, instr_d;
  logic                  valid_q, valid_d;
  logic                  req_q, req_d;
  logic                  squash_q, squash_d;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    tgt_d    = tgt_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    req_d    = req_q;
    squash_d = squash_q;
    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
        req_d   = 1'b1;
        addr_d  = pc_q;
      end
      ST_REQ: begin
        if (imem_ack) begin
          if (redirect) begin
            pc_d     = redirect_pc;
            addr_d   = redirect_pc;
            squash_d = 1'b0;
          end else if (squash_q) begin
            pc_d     = tgt_q;
            addr_d   = tgt_q;
            squash_d = 1'b0;
          end else begin
            instr_d = imem_data;
            valid_d = 1'b1;
            req_d   = 1'b0;
            state_d = ST_HOLD;
          end
        end else if (redirect) begin
          tgt_d    = redirect_pc;
          squash_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          valid_d = 1'b0;
          instr_d = NOP_WORD;
          pc_d    = redirect_pc;
          addr_d  = redirect_pc;
          req_d   = 1'b1;
          state_d = ST_REQ;
        end else if (!stall) begin
          valid_d = 1'b0;
          instr_d = NOP_WORD;
          if (instr_q[31:29] == OP_CTRL) begin
            state_d = ST_BWAIT;
          end else begin
            pc_d    = pc_q + ONE;
            addr_d  = pc_q + ONE;
            req_d   = 1'b1;
            state_d = ST_REQ;
          end
        end
      end
      ST_BWAIT: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          addr_d  = redirect_pc;
          req_d   = 1'b1;
          state_d = ST_REQ;
        end else if (branch_done) begin
          pc_d    = pc_q + ONE;
          addr_d  = pc_q + ONE;
          req_d   = 1'b1;
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      pcn_q    <= RESET_PC + ONE;
      addr_q   <= RESET_PC;
      tgt_q    <= RESET_PC;
      instr_q  <= NOP_WORD;
      valid_q  <= 1'b0;
      req_q    <= 1'b0;
      squash_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pcn_q    <= pc_d + ONE;
      addr_q   <= addr_d;
      tgt_q    <= tgt_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      req_q    <= req_d;
      squash_q <= squash_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign pc_next     = pcn_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the Lapido 32-bit processor. Holds the program counter and requests words from instruction memory over a request/acknowledge handshake. Presents one instruction at a time to the control unit, which samples it on `posedge clock`, and stalls after control-transfer instructions until the datapath resolves them. Applies redirects for jump, beq, bne, jal and jr.

## Interface
- `ADDR_WIDTH`, default 16: word-address width of instruction memory and PC.
- `RESET_PC`, default 0: first fetch address after reset.

Ports:
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `imem_req`  out  ADDR_WIDTH-agnostic 1  fetch request; held until `imem_ack`.
- `imem_addr`  out  ADDR_WIDTH  word address; stable while `imem_req`=1.
- `imem_ack`  in  1  `imem_data` valid this cycle; zero or more wait cycles.
- `imem_data`  in  32  fetched instruction word.
- `stall`  in  1  downstream cannot accept the presented instruction.
- `redirect`  in  1  taken branch, jump or jr from the datapath.
- `redirect_pc`  in  ADDR_WIDTH  target address, valid with `redirect`.
- `branch_done`  in  1  control transfer resolved not-taken.
- `instruction`  out  32  word to the control unit; 32'h0 (NOP) when invalid.
- `instr_valid`  out  1  `instruction` is a live fetched word.
- `pc`  out  ADDR_WIDTH  address of `instruction`.
- `pc_next`  out  ADDR_WIDTH  `pc`+1 modulo 2^ADDR_WIDTH (jal link value).

## Operation
- States: IDLE, REQ, HOLD, BWAIT.
- Reset outputs: state=IDLE, `pc`=RESET_PC, `imem_req`=0, `instruction`=0, `instr_valid`=0, `imem_addr`=RESET_PC, internal squash flag=0.
- IDLE → REQ unconditionally; `imem_addr`=`pc`.
- REQ: `imem_req`=1. On `imem_ack`:
  - If squash=0: capture `imem_data` into `instruction` and go to HOLD with `instr_valid`=1.
  - If squash=1: discard the word, clear squash, set `pc`/`imem_addr` to the saved target, and stay in REQ.
- A `redirect` in REQ before or with the ack never aborts the bus cycle. It saves `redirect_pc` and sets squash. If it arrives in the same cycle as the ack, the ack is the discarded one.
- HOLD: the instruction is accepted at an edge where `instr_valid`=1 and `stall`=0. On acceptance:
  - If `instruction[31:29]`==3'b101 (control transfer): go to BWAIT with `instr_valid`=0 and `instruction`=0.
  - Otherwise: set `pc`=`pc`+1 and go to REQ.
- BWAIT:
  - `redirect` → `pc`=`redirect_pc`, go to REQ.
  - `branch_done` alone → `pc`=`pc`+1, go to REQ.
  - Both asserted → `redirect` wins.
- `redirect` in HOLD (stale prefetch, e.g. an external exception path): drop `instr_valid`, set `pc`=`redirect_pc`, go to REQ. This has priority over `stall`.
- `redirect` and `branch_done` are ignored in IDLE.
- PC arithmetic is unsigned and wraps from 2^ADDR_WIDTH−1 to 0.
- Reset mid-transaction returns to IDLE. Any later `imem_ack` from the abandoned request is ignored because `imem_req`=0.

## Timing
- Zero-wait memory: REQ→HOLD in one cycle. Best throughput is one instruction per 2 cycles.
- Data latency: `instruction` and `instr_valid` are registered and update on the edge where `imem_ack`=1 is sampled.
- Redirect in BWAIT: the next `imem_req` rises the cycle after `redirect`.
- All outputs are registered; no combinational input→output paths.
- `pc_next` is registered alongside `pc`.

## Structure
- The shared package `lapido_pkg` holds:
  - opcode-class constants OP_NOP=3'b000, OP_ALU=3'b001, OP_CONST=3'b010, OP_MEM=3'b100, OP_CTRL=3'b101;
  - NOP_WORD=32'h0;
  - the fetch state enum.
- The control unit imports the same constants.
- No sub-module. PC register, FSM and squash logic stay in one module.

## Test plan
- Reset with RESET_PC=0x0010 and zero-wait memory returning an ALU word 0x20000000 → `imem_addr`=0x0010 at the first REQ; `instr_valid`=1 two cycles after reset release; `pc_next`=0x0011.
- `stall` held 3 cycles in HOLD → `instruction` and `pc` are stable; no `imem_req` until `stall` drops.
- Fetch jump word 0xA0000000 → BWAIT. `redirect` with `redirect_pc`=0x0040 → next `imem_addr`=0x0040. A separate beq case with `branch_done` only → `imem_addr`=`pc`+1.
- Memory with 3 wait cycles and `redirect`=0x0080 on wait cycle 1 → the acked word is discarded, `instr_valid` stays 0, and the next request is to 0x0080.
- `pc`=0xFFFF with ADDR_WIDTH=16 and a non-branch accepted → next `imem_addr`=0x0000; `redirect` and `branch_done` asserted together in BWAIT → `redirect_pc` is used.
